timed_seq_prog: RTL

//  Programmable timed pattern sequencer: plays a table of (data, duration) entries onto an output bus.
//  The table lives in an internal DEPTH-entry register file, written at runtime.
//  A start pulse plays entries 0..len-1 back to back with no gap cycles.

---
 rtl/timed_seq_prog_if.sv | 45 ++++
 rtl/timed_seq_prog.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/timed_seq_prog_if.sv
// Table-write, control and pattern-output bundle for timed_seq_prog.
// The loop control signal exists only when TIMED_SEQ_PROG_LOOP_EN is defined.
interface timed_seq_prog_if #(
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned DUR_BITS  = 26,
    parameter int unsigned DEPTH     = 16
);
    localparam int unsigned ADDR_BITS = $clog2(DEPTH);
    localparam int unsigned LEN_BITS  = $clog2(DEPTH + 1);

    logic                 wr_en;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [DATA_BITS-1:0] wr_data;
    logic [DUR_BITS-1:0]  wr_dur;
    logic [LEN_BITS-1:0]  len;
    logic                 start;
    logic                 stop;
`ifdef TIMED_SEQ_PROG_LOOP_EN
    logic                 loop;
`endif
    logic [DATA_BITS-1:0] data;
    logic                 busy;
    logic                 done;
    logic [ADDR_BITS-1:0] idx;

`ifdef TIMED_SEQ_PROG_LOOP_EN
    modport master (
        output wr_en, wr_addr, wr_data, wr_dur, len, start, stop, loop,
        input  data, busy, done, idx
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, wr_dur, len, start, stop, loop,
        output data, busy, done, idx
    );
`else
    modport master (
        output wr_en, wr_addr, wr_data, wr_dur, len, start, stop,
        input  data, busy, done, idx
    );
    modport slave (
        input  wr_en, wr_addr, wr_data, wr_dur, len, start, stop,
        output data, busy, done, idx
    );
`endif
endinterface

// File: rtl/timed_seq_prog.sv
// Programmable timed pattern sequencer: plays (data, duration) table entries back to back.
// Define TIMED_SEQ_PROG_LOOP_EN to enable continuous looping via the loop input.
module timed_seq_prog #(
    parameter int unsigned          DATA_BITS = 8,
    parameter int unsigned          DUR_BITS  = 26,
    parameter int unsigned          DEPTH     = 16,
    parameter logic [DATA_BITS-1:0] IDLE_DATA = '0
) (
    input logic             clk,
    input logic             rst_n,
    timed_seq_prog_if.slave bus
);
    localparam int unsigned         ADDR_BITS = $clog2(DEPTH);
    localparam int unsigned         LEN_BITS  = $clog2(DEPTH + 1);
    localparam int unsigned         ENT_BITS  = DATA_BITS + DUR_BITS;
    localparam logic [LEN_BITS-1:0] DEPTH_L   = LEN_BITS'(DEPTH);

    typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

    state_e               state_q, state_d;
    logic                 load_q, load_d;
    logic [LEN_BITS-1:0]  len_q, len_d, len_eff;
    logic [ADDR_BITS-1:0] idx_q, idx_d, rd_addr;
    logic [DATA_BITS-1:0] data_q, data_d, rd_data_q;
    logic [DUR_BITS-1:0]  dur_q, dur_d, rd_dur_q, cnt_q, cnt_d;
    logic                 busy_q, busy_d, done_q, done_d;
    logic                 entry_end, last_entry, do_wrap;
    logic [ENT_BITS-1:0]  tbl [DEPTH];
    logic [ENT_BITS-1:0]  rd_word;

    // Index that follows i within a pass of n entries; wraps to 0 after the last one.
    function automatic logic [ADDR_BITS-1:0] next_idx(input logic [ADDR_BITS-1:0] i,
                                                      input logic [LEN_BITS-1:0]  n);
        logic [LEN_BITS-1:0] i1;
        i1 = LEN_BITS'(i) + LEN_BITS'(1);
        return (i1 >= n) ? '0 : ADDR_BITS'(i1);
    endfunction

    assign len_eff    = (bus.len > DEPTH_L) ? DEPTH_L : bus.len;
    assign entry_end  = (cnt_q >= ((dur_q == '0) ? DUR_BITS'(1) : dur_q));
    assign last_entry = ((LEN_BITS'(idx_q) + LEN_BITS'(1)) >= len_q);

    always_ff @(posedge clk) begin
        if (bus.wr_en) begin
            tbl[bus.wr_addr] <= {bus.wr_data, bus.wr_dur};
        end
    end

    // Same-cycle write to the prefetch address forwards the new entry.
    assign rd_word = (bus.wr_en && (bus.wr_addr == rd_addr)) ? {bus.wr_data, bus.wr_dur}
                                                              : tbl[rd_addr];

    always_comb begin
        state_d = state_q;
        load_d  = 1'b0;
        len_d   = len_q;
        idx_d   = idx_q;
        data_d  = data_q;
        dur_d   = dur_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rd_addr = '0;
        do_wrap = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start && !bus.stop && (len_eff != '0)) begin
                    state_d = StFetch;
                    len_d   = len_eff;
                end
            end
            StFetch: begin
                state_d = StHold;
                load_d  = 1'b1;
            end
            StHold: begin
                if (load_q) begin
                    data_d  = rd_data_q;
                    dur_d   = rd_dur_q;
                    idx_d   = '0;
                    cnt_d   = DUR_BITS'(1);
                    busy_d  = 1'b1;
                    rd_addr = next_idx('0, len_q);
                end else if (!entry_end) begin
                    cnt_d   = cnt_q + DUR_BITS'(1);
                    rd_addr = next_idx(idx_q, len_q);
                end else if (!last_entry) begin
                    data_d  = rd_data_q;
                    dur_d   = rd_dur_q;
                    idx_d   = idx_q + ADDR_BITS'(1);
                    cnt_d   = DUR_BITS'(1);
                    rd_addr = next_idx(idx_q + ADDR_BITS'(1), len_q);
                end else begin
                    done_d = 1'b1;
`ifdef TIMED_SEQ_PROG_LOOP_EN
                    do_wrap = bus.loop && (len_eff != '0);
`endif
                    if (do_wrap) begin
                        // Entry 0 is already in the prefetch register.
                        data_d  = rd_data_q;
                        dur_d   = rd_dur_q;
                        idx_d   = '0;
                        cnt_d   = DUR_BITS'(1);
                        len_d   = len_eff;
                        rd_addr = next_idx('0, len_eff);
                    end else begin
                        state_d = StIdle;
                        data_d  = IDLE_DATA;
                        busy_d  = 1'b0;
                        idx_d   = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (bus.stop && (state_q != StIdle)) begin
            state_d = StIdle;
            load_d  = 1'b0;
            data_d  = IDLE_DATA;
            busy_d  = 1'b0;
            idx_d   = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            load_q    <= 1'b0;
            len_q     <= '0;
            idx_q     <= '0;
            data_q    <= IDLE_DATA;
            dur_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_data_q <= '0;
            rd_dur_q  <= '0;
        end else begin
            state_q   <= state_d;
            load_q    <= load_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            dur_q     <= dur_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_data_q <= rd_word[ENT_BITS-1:DUR_BITS];
            rd_dur_q  <= rd_word[DUR_BITS-1:0];
        end
    end

    assign bus.data = data_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.idx  = idx_q;
endmodule
